// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths and the transmit-buffer FSM state type.
package uart_pkg;

    // Defaults shared by uart_tx, its receiver counterpart and the transmit buffer
    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } tx_buf_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-file storage for the transmit FIFO: synchronous write, asynchronous read.
module uart_fifo_mem #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_BITS-1:0]  wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_BITS-1:0]  rdata_o
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_WIDTH];

    // Store the incoming byte at the write pointer; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer in front of uart_tx: a synchronous FIFO plus a read-side FSM that
// pops one byte, pulses tx_start, and waits for tx_done before the next pop.
// Optional overflow flag (ovf/ovf_clr) is built when UART_TX_BUF_OVF_EN is defined.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned ADDR_WIDTH = UART_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_BITS-1:0]  wr_data,
`ifdef UART_TX_BUF_OVF_EN
    input  logic                  ovf_clr,
    output logic                  ovf,
`endif
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  tx_start,
    output logic [DATA_BITS-1:0]  tx_din,
    input  logic                  tx_done
);

    localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_BITS-1:0]  tx_din_q, tx_din_d;
    logic [DATA_BITS-1:0]  head_data;
    tx_buf_state_t         state_q, state_d;
    logic                  wr_accept;
    logic                  pop;

    // Flags come from the registered count only
    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign count = count_q;

    // A write while full is dropped even if a pop frees a slot in the same cycle
    assign wr_accept = wr_en && !full;
    assign pop       = (state_q == S_IDLE) && !empty;

    uart_fifo_mem #(
        .DATA_BITS  (DATA_BITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en_i (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

    // Pointer, occupancy and output-byte next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tx_din_d = tx_din_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            tx_din_d = head_data;
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping and held output byte; reset flushes queued data
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tx_din_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tx_din_q <= tx_din_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; tx_done outside S_WAIT is ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!empty) state_d = S_LOAD;
            S_LOAD:  state_d = S_WAIT;
            S_WAIT:  if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register, so tx_start is one clean cycle
    always_comb begin
        tx_start = (state_q == S_LOAD);
        busy     = (state_q != S_IDLE);
        tx_din   = tx_din_q;
    end

`ifdef UART_TX_BUF_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow flag; a new overflow beats a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a uart_tx stand-in answers tx_start with
// tx_done after a programmable delay and records every byte it is handed; those are
// compared in order against a queue of the bytes the FIFO should have accepted.
module tb_uart_tx_buffer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          busy;
    logic          tx_start;
    logic [DW-1:0] tx_din;
    logic          tx_done;
`ifdef UART_TX_BUF_OVF_EN
    logic          ovf_clr;
    logic          ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    bit         auto_done = 1'b1;
    bit         hold_done = 1'b0;
    int         done_dly  = 10;
    int         n_starts  = 0;

    uart_tx_buffer #(
        .DATA_BITS  (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
`ifdef UART_TX_BUF_OVF_EN
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
`endif
        .full     (full),
        .empty    (empty),
        .count    (count),
        .busy     (busy),
        .tx_start (tx_start),
        .tx_din   (tx_din),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Wait for the buffer to go idle and empty, then compare delivered vs accepted bytes
    task automatic check_drain(input string tag);
        bit to = 1'b1;
        int n;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && empty) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        chk({tag, "_timeout"}, 32'(to), 32'd0);
        chk({tag, "_nbytes"}, 32'(cap_q.size()), 32'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    // uart_tx stand-in: capture each started byte, answer with a one-cycle tx_done
    initial begin : responder
        bit pending;
        int dly;
        pending = 1'b0;
        dly     = 0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_done) tx_done = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (pending && !hold_done) begin
                    if (dly == 0) begin
                        if (auto_done) tx_done = 1'b1;
                        pending = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                if (tx_start) begin
                    cap_q.push_back(tx_din);
                    n_starts++;
                    pending = 1'b1;
                    dly     = done_dly - 1;
                end
            end
        end
    end

    initial begin : main
        logic [7:0] b;
        bit         to;
        int         extra_start;
        int         din_moved;
        int         s0;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_done = 1'b0;
`ifdef UART_TX_BUF_OVF_EN
        ovf_clr = 1'b0;
`endif
        repeat (2) tick();
        reset = 1'b0;

        // Reset state, then after 20 idle cycles
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        repeat (20) tick();
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_full", 32'(full), 32'd0);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_start", 32'(tx_start), 32'd0);
        chk("idle_din", 32'(tx_din), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
`ifdef UART_TX_BUF_OVF_EN
        chk("idle_ovf", 32'(ovf), 32'd0);
`endif

        // Single byte: write at edge N
        exp_q.push_back(8'hA5);
        wr(8'hA5);
        chk("a5_n_empty", 32'(empty), 32'd0);
        chk("a5_n_count", 32'(count), 32'd1);
        chk("a5_n_start", 32'(tx_start), 32'd0);
        tick();
        chk("a5_n1_din", 32'(tx_din), 32'hA5);
        chk("a5_n1_start", 32'(tx_start), 32'd1);
        chk("a5_n1_busy", 32'(busy), 32'd1);
        chk("a5_n1_empty", 32'(empty), 32'd1);
        tick();
        chk("a5_n2_start", 32'(tx_start), 32'd0);
        to          = 1'b1;
        extra_start = 0;
        din_moved   = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            if (tx_start) extra_start++;
            if (tx_din !== 8'hA5) din_moved++;
            tick();
        end
        chk("a5_busy_timeout", 32'(to), 32'd0);
        chk("a5_extra_start", 32'(extra_start), 32'd0);
        chk("a5_din_held", 32'(din_moved), 32'd0);
        chk("a5_idle_after_done", 32'(tx_done), 32'd1);
        chk("a5_empty_after", 32'(empty), 32'd1);
        check_drain("a5");

        // Fill to full with tx_done withheld; an extra write is dropped
        hold_done = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            b = 8'(i);
            exp_q.push_back(b);
            wr(b);
        end
        chk("fill_count15", 32'(count), 32'd15);
        chk("fill_notfull", 32'(full), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        exp_q.push_back(8'h11);
        wr(8'h11);
        chk("fill_count16", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        wr(8'hFF);
        chk("drop_count16", 32'(count), 32'd16);
        chk("drop_full", 32'(full), 32'd1);
        hold_done = 1'b0;
        check_drain("fill");

        // Simultaneous write and pop at count=3, tx_done driven by hand
        hold_done = 1'b1;
        auto_done = 1'b0;
        tx_done   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom());
            exp_q.push_back(b);
            wr(b);
        end
        tick();
        chk("sim_pre_count", 32'(count), 32'd3);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        b = 8'($urandom());
        exp_q.push_back(b);
        wr(b);
        chk("sim_count3", 32'(count), 32'd3);
        chk("sim_start", 32'(tx_start), 32'd1);
        auto_done = 1'b1;
        hold_done = 1'b0;
        check_drain("sim");

        // 40 random bytes with a continuously draining consumer; pointers wrap
        done_dly = 2;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom());
            exp_q.push_back(b);
            wr(b);
            repeat ($urandom_range(3, 8)) tick();
        end
        check_drain("wrap");

        // Reset while waiting for tx_done with 5 bytes queued
        done_dly  = 10;
        hold_done = 1'b1;
        for (int i = 0; i < 6; i++) wr(8'($urandom()));
        tick();
        chk("rstw_count5", 32'(count), 32'd5);
        chk("rstw_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_count0", 32'(count), 32'd0);
        chk("rstw_empty", 32'(empty), 32'd1);
        chk("rstw_idle", 32'(busy), 32'd0);
        chk("rstw_din", 32'(tx_din), 32'd0);
        hold_done = 1'b0;
        s0 = n_starts;
        repeat (30) tick();
        chk("rstw_no_start", 32'(n_starts - s0), 32'd0);
        chk("rstw_still_empty", 32'(empty), 32'd1);
        cap_q.delete();
        exp_q.delete();

`ifdef UART_TX_BUF_OVF_EN
        // Overflow flag: sticky set, clear, and set-beats-clear
        chk("ovf_after_rst", 32'(ovf), 32'd0);
        hold_done = 1'b1;
        for (int i = 0; i < 17; i++) wr(8'($urandom()));
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_not_yet", 32'(ovf), 32'd0);
        wr(8'hEE);
        chk("ovf_set", 32'(ovf), 32'd1);
        repeat (3) tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        ovf_clr = 1'b1;
        wr(8'hEF);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hold_done = 1'b0;
        chk("ovf_reset", 32'(ovf), 32'd0);
        cap_q.delete();
        exp_q.delete();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
